// File: rtl/cosim_commit_collector.sv
// Collects one retired instruction's register writes into a bundle and
// streams double-buffered bundles to the cosim comparator one entry per beat.
module cosim_commit_collector #(
    parameter int Entries = 16,
    parameter int KeyW    = 64,
    parameter int ValW    = 128,
    parameter int PcW     = 64,
    localparam int CntW   = $clog2(Entries + 1),
    localparam int IdxW   = $clog2(Entries)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_valid_i,
    input  logic [KeyW-1:0] wr_key_i,
    input  logic [ValW-1:0] wr_value_i,
    input  logic            retire_valid_i,
    input  logic [PcW-1:0]  retire_pc_i,
    output logic            in_ready_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PcW-1:0]  out_pc_o,
    output logic [CntW-1:0] out_count_o,
    output logic [IdxW-1:0] out_idx_o,
    output logic            out_entry_valid_o,
    output logic [KeyW-1:0] out_key_o,
    output logic [ValW-1:0] out_value_o,
    output logic            out_last_o,
    output logic            overflow_o
);

    typedef enum logic {EMPTY, STREAM} state_t;

    logic [KeyW-1:0] key_q [2][Entries];
    logic [ValW-1:0] val_q [2][Entries];
    logic [CntW-1:0] cnt_q [2];
    logic [PcW-1:0]  pc_q  [2];

    logic            fill_q;
    logic            closed_q;
    state_t          state_q;
    logic [IdxW-1:0] idx_q;
    logic            ovf_q;

    logic            drain_sel;
    logic [CntW-1:0] fill_cnt;
    logic [CntW-1:0] drain_cnt;
    logic            room;
    logic            acc_wr;
    logic            do_wr;
    logic            acc_ret;
    logic            beat;
    logic            done;
    logic            can_swap;
    logic            swap;
    logic [CntW-1:0] new_cnt;

    assign drain_sel = ~fill_q;
    assign fill_cnt  = cnt_q[fill_q];
    assign drain_cnt = cnt_q[drain_sel];

    assign in_ready_o = !closed_q;
    assign room       = fill_cnt != CntW'(Entries);
    assign acc_wr     = in_ready_o && wr_valid_i;
    assign do_wr      = acc_wr && room;
    assign acc_ret    = in_ready_o && retire_valid_i;
    assign new_cnt    = fill_cnt + CntW'(do_wr);

    assign beat     = out_valid_o && out_ready_i;
    assign done     = beat && out_last_o;
    assign can_swap = (state_q == EMPTY) || done;
    // A closed bundle only exists while the drain bank is busy.
    assign swap     = (acc_ret || closed_q) && can_swap;

    assign out_valid_o       = state_q == STREAM;
    assign out_entry_valid_o = out_valid_o && (drain_cnt != '0);
    assign out_last_o        = out_valid_o &&
                               ((drain_cnt == '0) ||
                                (CntW'(idx_q) == drain_cnt - CntW'(1)));
    assign out_idx_o   = idx_q;
    assign out_count_o = out_valid_o ? drain_cnt : '0;
    assign out_pc_o    = out_valid_o ? pc_q[drain_sel] : '0;
    assign out_key_o   = out_entry_valid_o ? key_q[drain_sel][idx_q] : '0;
    assign out_value_o = out_entry_valid_o ? val_q[drain_sel][idx_q] : '0;
    assign overflow_o  = ovf_q;

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            key_q[fill_q][fill_cnt[IdxW-1:0]] <= wr_key_i;
            val_q[fill_q][fill_cnt[IdxW-1:0]] <= wr_value_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q   <= 1'b0;
            closed_q <= 1'b0;
            state_q  <= EMPTY;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            pc_q[0]  <= '0;
            pc_q[1]  <= '0;
        end else begin
            if (acc_wr && !room)
                ovf_q <= 1'b1;
            if (do_wr)
                cnt_q[fill_q] <= new_cnt;
            if (acc_ret) begin
                cnt_q[fill_q] <= new_cnt;
                pc_q[fill_q]  <= retire_pc_i;
                if (!can_swap)
                    closed_q <= 1'b1;
            end
            if (swap) begin
                fill_q           <= drain_sel;
                cnt_q[drain_sel] <= '0;
                closed_q         <= 1'b0;
            end
            if (beat)
                idx_q <= out_last_o ? '0 : idx_q + IdxW'(1);
            if (swap)
                state_q <= STREAM;
            else if (done)
                state_q <= EMPTY;
        end
    end

endmodule

// File: tb/tb_cosim_commit_collector.sv
// Self-checking bench: directed vector table, hand-written corner cases and
// randomized traffic against a bundle-level queue model.
module tb_cosim_commit_collector;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         wr_valid = 1'b0;
    logic [63:0]  wr_key = '0;
    logic [127:0] wr_value = '0;
    logic         retire_valid = 1'b0;
    logic [63:0]  retire_pc = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_pc;
    logic [4:0]   out_count;
    logic [3:0]   out_idx;
    logic         out_entry_valid;
    logic [63:0]  out_key;
    logic [127:0] out_value;
    logic         out_last;
    logic         overflow;

    int n_chk = 0;
    int n_fail = 0;

    cosim_commit_collector dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .wr_valid_i(wr_valid),
        .wr_key_i(wr_key),
        .wr_value_i(wr_value),
        .retire_valid_i(retire_valid),
        .retire_pc_i(retire_pc),
        .in_ready_o(in_ready),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_pc_o(out_pc),
        .out_count_o(out_count),
        .out_idx_o(out_idx),
        .out_entry_valid_o(out_entry_valid),
        .out_key_o(out_key),
        .out_value_o(out_value),
        .out_last_o(out_last),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string t, bit rdy, bit vld, bit last, bit ev,
                           int cnt, int idx, logic [63:0] key,
                           logic [127:0] val, logic [63:0] pc);
        chk({t, ".rdy"}, 128'(in_ready), 128'(rdy));
        chk({t, ".vld"}, 128'(out_valid), 128'(vld));
        chk({t, ".last"}, 128'(out_last), 128'(last));
        chk({t, ".ev"}, 128'(out_entry_valid), 128'(ev));
        chk({t, ".cnt"}, 128'(out_count), 128'(cnt));
        chk({t, ".idx"}, 128'(out_idx), 128'(idx));
        chk({t, ".key"}, 128'(out_key), 128'(key));
        chk({t, ".val"}, out_value, val);
        chk({t, ".pc"}, 128'(out_pc), 128'(pc));
    endtask

    task automatic drive(bit w, logic [63:0] k, logic [127:0] v,
                         bit r, logic [63:0] p, bit ordy);
        wr_valid = w;
        wr_key = k;
        wr_value = v;
        retire_valid = r;
        retire_pc = p;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, '0, 0);
        rst_ni = 1'b0;
        repeat (2) tick();
        chk_out("reset", 1, 0, 0, 0, 0, 0, '0, '0, '0);
        chk("reset.ovf", 128'(overflow), 128'(0));
        rst_ni = 1'b1;
    endtask

    typedef struct {
        bit           wr;
        logic [63:0]  key;
        logic [127:0] val;
        bit           ret;
        logic [63:0]  pc;
        bit           ordy;
        bit           e_rdy, e_vld, e_last, e_ev;
        int           e_cnt, e_idx;
        logic [63:0]  e_key;
        logic [127:0] e_val;
        logic [63:0]  e_pc;
    } vec_t;

    function automatic vec_t mk(bit w, logic [63:0] k, logic [127:0] v,
                                bit r, logic [63:0] p, bit o,
                                bit vl, bit la, bit ev, int c, int i,
                                logic [63:0] ek, logic [127:0] evl,
                                logic [63:0] ep);
        vec_t x;
        x.wr = w; x.key = k; x.val = v; x.ret = r; x.pc = p; x.ordy = o;
        x.e_rdy = 1'b1; x.e_vld = vl; x.e_last = la; x.e_ev = ev;
        x.e_cnt = c; x.e_idx = i; x.e_key = ek; x.e_val = evl; x.e_pc = ep;
        return x;
    endfunction

    // Bundle-level reference model
    logic [63:0]  f_key[16], d_key[16], h_key[16];
    logic [127:0] f_val[16], d_val[16], h_val[16];
    int           f_n, d_n, h_n, d_i;
    logic [63:0]  d_pc, h_pc;
    bit           d_v, h_v, m_ovf;

    function automatic bit m_last();
        return d_v && (d_n == 0 || d_i == d_n - 1);
    endfunction

    task automatic m_reset();
        f_n = 0; d_n = 0; h_n = 0; d_i = 0;
        d_v = 0; h_v = 0; m_ovf = 0; d_pc = '0; h_pc = '0;
    endtask

    task automatic m_step(bit w, logic [63:0] k, logic [127:0] v,
                          bit r, logic [63:0] p, bit o);
        bit done, loaded;
        done = d_v && o && m_last();
        loaded = 0;
        if (!h_v) begin
            if (w) begin
                if (f_n < 16) begin
                    f_key[f_n] = k; f_val[f_n] = v; f_n++;
                end else m_ovf = 1;
            end
            if (r) begin
                if (!d_v || done) begin
                    d_key = f_key; d_val = f_val; d_n = f_n; d_pc = p;
                    d_i = 0; d_v = 1; loaded = 1;
                end else begin
                    h_key = f_key; h_val = f_val; h_n = f_n; h_pc = p;
                    h_v = 1;
                end
                f_n = 0;
            end
        end else if (done) begin
            d_key = h_key; d_val = h_val; d_n = h_n; d_pc = h_pc;
            d_i = 0; h_v = 0; loaded = 1;
        end
        if (!loaded && d_v && o) begin
            if (m_last()) begin
                d_v = 0; d_i = 0;
            end else d_i++;
        end
    endtask

    task automatic m_check();
        bit ev;
        ev = d_v && d_n > 0;
        chk_out("rand", !h_v, d_v, m_last(), ev, d_v ? d_n : 0, d_i,
                ev ? d_key[d_i] : 64'h0, ev ? d_val[d_i] : 128'h0,
                d_v ? d_pc : 64'h0);
        chk("rand.ovf", 128'(overflow), 128'(m_ovf));
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(1, 64'h00A0, 128'h1234, 1, 64'h8000_0000, 1,
                     1, 1, 1, 1, 0, 64'h00A0, 128'h1234, 64'h8000_0000);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 64'h8000_0004, 1,
                     1, 1, 0, 0, 0, 0, 0, 64'h8000_0004);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 64'h0050, 128'h11, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 64'h0031, 128'h22, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 64'h3004, 128'h33, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 64'h8000_0008, 0,
                     1, 0, 1, 3, 0, 64'h0050, 128'h11, 64'h8000_0008);
        for (int i = 8; i < 11; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 0,
                        1, 0, 1, 3, 0, 64'h0050, 128'h11, 64'h8000_0008);
        tbl[11] = mk(0, 0, 0, 0, 0, 1,
                     1, 0, 1, 3, 1, 64'h0031, 128'h22, 64'h8000_0008);
        tbl[12] = mk(0, 0, 0, 0, 0, 1,
                     1, 1, 1, 3, 2, 64'h3004, 128'h33, 64'h8000_0008);
        tbl[13] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].wr, tbl[i].key, tbl[i].val,
                  tbl[i].ret, tbl[i].pc, tbl[i].ordy);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vld,
                    tbl[i].e_last, tbl[i].e_ev, tbl[i].e_cnt, tbl[i].e_idx,
                    tbl[i].e_key, tbl[i].e_val, tbl[i].e_pc);
        end

        // Stall: third retire must wait for the held bundle to swap
        drive(1, 64'h10, 128'hA1, 1, 64'h100, 0);
        tick();
        chk_out("stall1", 1, 1, 1, 1, 1, 0, 64'h10, 128'hA1, 64'h100);
        drive(1, 64'h20, 128'hA2, 1, 64'h104, 0);
        tick();
        chk_out("stall2", 0, 1, 1, 1, 1, 0, 64'h10, 128'hA1, 64'h100);
        drive(1, 64'h30, 128'hA3, 1, 64'h108, 0);
        repeat (2) begin
            tick();
            chk_out("stall3", 0, 1, 1, 1, 1, 0, 64'h10, 128'hA1, 64'h100);
        end
        out_ready = 1'b1;
        tick();
        chk_out("drain2", 1, 1, 1, 1, 1, 0, 64'h20, 128'hA2, 64'h104);
        tick();
        chk_out("drain3", 1, 1, 1, 1, 1, 0, 64'h30, 128'hA3, 64'h108);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk_out("drained", 1, 0, 0, 0, 0, 0, '0, '0, '0);

        // Overflow: 17 writes, first 16 kept
        for (int i = 0; i < 17; i++) begin
            drive(1, 64'(i) << 4, 128'(i + 1), 0, 0, 1);
            tick();
            if (i == 15) chk("ovf.pre", 128'(overflow), 128'(0));
        end
        chk("ovf.set", 128'(overflow), 128'(1));
        drive(0, 0, 0, 1, 64'h200, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 16; j++) begin
            chk_out($sformatf("ovf.b%0d", j), 1, 1, j == 15, 1, 16, j,
                    64'(j) << 4, 128'(j + 1), 64'h200);
            tick();
        end
        chk("ovf.end_vld", 128'(out_valid), 128'(0));
        chk("ovf.sticky", 128'(overflow), 128'(1));

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h40 + 64'(i), 128'h70 + 128'(i), 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 1, 64'h300, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("mid.idx1", 128'(out_idx), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk_out("mid.rst", 1, 0, 0, 0, 0, 0, '0, '0, '0);
        chk("mid.ovf", 128'(overflow), 128'(0));
        tick();
        rst_ni = 1'b1;
        drive(1, 64'h00A0, 128'h55, 1, 64'h304, 1);
        tick();
        chk_out("mid.fresh", 1, 1, 1, 1, 1, 0, 64'h00A0, 128'h55, 64'h304);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("mid.done", 128'(out_valid), 128'(0));

        // Randomized traffic against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            bit w, r, o;
            logic [63:0] k, p;
            logic [127:0] v;
            m_check();
            if (h_v) begin
                w = wr_valid; k = wr_key; v = wr_value;
                r = retire_valid; p = retire_pc;
            end else begin
                w = ($urandom_range(0, 99) < 55);
                r = ($urandom_range(0, 99) < 30);
                k = {$urandom, $urandom};
                v = {$urandom, $urandom, $urandom, $urandom};
                p = {$urandom, $urandom};
            end
            o = ($urandom_range(0, 99) < 70);
            drive(w, k, v, r, p, o);
            m_step(w, k, v, r, p, o);
            tick();
        end
        m_check();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
